// File: rtl/dds_conf_decoder.sv
// rtl/dds_conf_decoder.sv - multi-channel DDS configuration frame decoder
//
// Parses framed 32-bit words (HEADER, CTRL, FREQ, PHASE, WAVE, TRAILER)
// and commits frequency, phase and waveform settings into one of CH_NUM
// per-channel banks. A bank changes only when a well-formed frame ends
// with a valid trailer.
//
// Ports:
//   axi_clk       - single clock, rising edge
//   rst           - asynchronous active-low reset
//   conf_data     - configuration word, sampled when conf_valid is high
//   conf_valid    - word qualifier
//   dds_work_flag - global enable; low aborts parsing and masks dds_en
//   set_flag      - one-cycle pulse on bank commit
//   set_ch        - channel of the most recent commit
//   frame_err     - one-cycle pulse on a rejected or timed-out frame
//   dds_en        - per-channel enable, gated by registered dds_work_flag
//   f_word        - per-channel 32-bit frequency words, channel k at [32k+:32]
//   p_word        - per-channel phase words, packed the same way
//   wave_type     - per-channel waveform types, packed the same way
module dds_conf_decoder #(
    parameter int CH_NUM      = 4,
    parameter int PW_WIDTH    = 12,
    parameter int WT_WIDTH    = 2,
    parameter int TIMEOUT_CYC = 1024,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                         axi_clk,
    input  logic                         rst,
    input  logic [31:0]                  conf_data,
    input  logic                         conf_valid,
    input  logic                         dds_work_flag,
    output logic                         set_flag,
    output logic [CH_W-1:0]              set_ch,
    output logic                         frame_err,
    output logic [CH_NUM-1:0]            dds_en,
    output logic [CH_NUM*32-1:0]         f_word,
    output logic [CH_NUM*PW_WIDTH-1:0]   p_word,
    output logic [CH_NUM*WT_WIDTH-1:0]   wave_type
);

    localparam logic [31:0] HDR_WORD = 32'hFFFF_FFFF;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CTRL  = 3'd1;
    localparam logic [2:0] S_FREQ  = 3'd2;
    localparam logic [2:0] S_PHASE = 3'd3;
    localparam logic [2:0] S_WAVE  = 3'd4;
    localparam logic [2:0] S_TRAIL = 3'd5;

    // The counter never needs to hold TIMEOUT_CYC itself: the edge on which
    // it would get there is the edge that raises the timeout, so it stops at
    // TIMEOUT_CYC-1 and cannot wrap.
    localparam int             TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [2:0]          r_state;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_work;
    logic                r_set_flag;
    logic                r_frame_err;
    logic [CH_W-1:0]     r_set_ch;

    logic [CH_W-1:0]     r_sh_ch;
    logic                r_sh_bad;
    logic                r_sh_en;
    logic [31:0]         r_sh_f;
    logic [PW_WIDTH-1:0] r_sh_p;
    logic [WT_WIDTH-1:0] r_sh_w;

    logic [CH_NUM-1:0]   r_en;
    logic [31:0]         r_f [CH_NUM];
    logic [PW_WIDTH-1:0] r_p [CH_NUM];
    logic [WT_WIDTH-1:0] r_w [CH_NUM];

    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_tmo       <= '0;
            r_work      <= 1'b0;
            r_set_flag  <= 1'b0;
            r_frame_err <= 1'b0;
            r_set_ch    <= '0;
            r_sh_ch     <= '0;
            r_sh_bad    <= 1'b0;
            r_sh_en     <= 1'b0;
            r_sh_f      <= '0;
            r_sh_p      <= '0;
            r_sh_w      <= '0;
            r_en        <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                r_f[k] <= '0;
                r_p[k] <= '0;
                r_w[k] <= '0;
            end
        end else begin
            r_set_flag  <= 1'b0;
            r_frame_err <= 1'b0;
            r_work      <= dds_work_flag;
            if (!dds_work_flag) begin
                // Silent abort: no error pulse, words ignored, banks kept.
                r_state <= S_IDLE;
                r_tmo   <= '0;
            end else if (r_state != S_IDLE && !conf_valid) begin
                if (r_tmo == TMO_LAST) begin
                    r_state     <= S_IDLE;
                    r_tmo       <= '0;
                    r_frame_err <= 1'b1;
                    r_sh_bad    <= 1'b0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else if (conf_valid) begin
                r_tmo <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (conf_data == HDR_WORD) begin
                            r_state <= S_CTRL;
                        end
                    end
                    S_CTRL: begin
                        r_sh_en  <= conf_data[31];
                        r_sh_ch  <= conf_data[CH_W-1:0];
                        // Out-of-range channel is remembered and reported
                        // at the trailer so the frame is still consumed whole.
                        r_sh_bad <= (conf_data[7:0] >= 8'(CH_NUM));
                        r_state  <= S_FREQ;
                    end
                    S_FREQ: begin
                        r_sh_f  <= conf_data;
                        r_state <= S_PHASE;
                    end
                    S_PHASE: begin
                        r_sh_p  <= conf_data[PW_WIDTH-1:0];
                        r_state <= S_WAVE;
                    end
                    S_WAVE: begin
                        r_sh_w  <= conf_data[WT_WIDTH-1:0];
                        r_state <= S_TRAIL;
                    end
                    S_TRAIL: begin
                        // A bad trailer is not re-parsed as a header.
                        r_state <= S_IDLE;
                        if (conf_data == HDR_WORD && !r_sh_bad) begin
                            r_f[r_sh_ch]  <= r_sh_f;
                            r_p[r_sh_ch]  <= r_sh_p;
                            r_w[r_sh_ch]  <= r_sh_w;
                            r_en[r_sh_ch] <= r_sh_en;
                            r_set_ch      <= r_sh_ch;
                            r_set_flag    <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign set_flag  = r_set_flag;
    assign frame_err = r_frame_err;
    assign set_ch    = r_set_ch;
    assign dds_en    = r_en & {CH_NUM{r_work}};

    for (genvar g = 0; g < CH_NUM; g++) begin : g_pack
        assign f_word[32*g +: 32]              = r_f[g];
        assign p_word[PW_WIDTH*g +: PW_WIDTH]  = r_p[g];
        assign wave_type[WT_WIDTH*g +: WT_WIDTH] = r_w[g];
    end

endmodule

// File: tb/tb_dds_conf_decoder.sv
// tb/tb_dds_conf_decoder.sv - self-checking bench for dds_conf_decoder
module tb_dds_conf_decoder;

    localparam logic [31:0] HDR = 32'hFFFF_FFFF;
    localparam int TMO = 1024;

    logic         clk;
    logic         rst;
    logic [31:0]  conf_data;
    logic         conf_valid;
    logic         dds_work_flag;
    logic         set_flag;
    logic [1:0]   set_ch;
    logic         frame_err;
    logic [3:0]   dds_en;
    logic [127:0] f_word;
    logic [47:0]  p_word;
    logic [7:0]   wave_type;

    dds_conf_decoder #(
        .CH_NUM(4), .PW_WIDTH(12), .WT_WIDTH(2), .TIMEOUT_CYC(TMO)
    ) dut (
        .axi_clk(clk), .rst(rst), .conf_data(conf_data), .conf_valid(conf_valid),
        .dds_work_flag(dds_work_flag), .set_flag(set_flag), .set_ch(set_ch),
        .frame_err(frame_err), .dds_en(dds_en), .f_word(f_word),
        .p_word(p_word), .wave_type(wave_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        work;
        logic        exp_set;
        logic        exp_err;
        logic [3:0]  exp_en;
        logic [31:0] exp_f3;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;
    int n_set = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] d, input logic v, input logic w,
                       input logic es, input logic ee, input logic [3:0] en,
                       input logic [31:0] f3);
        vec_t r;
        r.data = d; r.valid = v; r.work = w;
        r.exp_set = es; r.exp_err = ee; r.exp_en = en; r.exp_f3 = f3;
        vt.push_back(r);
    endtask

    task automatic step(input logic [31:0] d, input logic v, input logic w);
        @(negedge clk);
        conf_data = d;
        conf_valid = v;
        dds_work_flag = w;
        @(posedge clk);
        #1;
        if (set_flag) n_set++;
        if (frame_err) n_err++;
        if (set_flag && frame_err) chk("set_err_exclusive", 1, 0);
    endtask

    task automatic idle(input int n, input logic w);
        for (int i = 0; i < n; i++) step(32'h0, 1'b0, w);
    endtask

    task automatic frame(input logic [31:0] c, input logic [31:0] f, input logic [31:0] p,
                         input logic [31:0] wv, input int gap, input logic w);
        step(HDR, 1'b1, w); idle(gap, w);
        step(c,   1'b1, w); idle(gap, w);
        step(f,   1'b1, w); idle(gap, w);
        step(p,   1'b1, w); idle(gap, w);
        step(wv,  1'b1, w); idle(gap, w);
        step(HDR, 1'b1, w);
    endtask

    task automatic chk_bank(input int k, input logic [31:0] f, input logic [11:0] p,
                            input logic [1:0] w);
        chk($sformatf("f_word_ch%0d", k), f_word[32*k +: 32], f);
        chk($sformatf("p_word_ch%0d", k), p_word[12*k +: 12], p);
        chk($sformatf("wave_ch%0d", k), wave_type[2*k +: 2], w);
    endtask

    initial begin
        int s0, e0, err_at;

        rst = 1'b0;
        conf_data = '0;
        conf_valid = 1'b0;
        dds_work_flag = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_set_flag", set_flag, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_set_ch", set_ch, 0);
        chk("rst_dds_en", dds_en, 0);
        chk("rst_f_word", f_word, 0);
        chk("rst_p_word", p_word, 0);
        chk("rst_wave", wave_type, 0);
        @(negedge clk);
        rst = 1'b1;

        // Frame A: channel 1 enabled
        add(HDR,           1, 1, 0, 0, 4'b0000, 0);
        add(32'h8000_0001, 1, 1, 0, 0, 4'b0000, 0);
        add(32'd1000,      1, 1, 0, 0, 4'b0000, 0);
        add(32'd2048,      1, 1, 0, 0, 4'b0000, 0);
        add(32'd2,         1, 1, 0, 0, 4'b0000, 0);
        add(HDR,           1, 1, 1, 0, 4'b0010, 0);
        add(32'h0,         0, 1, 0, 0, 4'b0010, 0);
        // Frame B: channel 3, all-ones FREQ payload, bad trailer
        add(HDR,           1, 1, 0, 0, 4'b0010, 0);
        add(32'h8000_0003, 1, 1, 0, 0, 4'b0010, 0);
        add(HDR,           1, 1, 0, 0, 4'b0010, 0);
        add(32'd5,         1, 1, 0, 0, 4'b0010, 0);
        add(32'd1,         1, 1, 0, 0, 4'b0010, 0);
        add(32'h0,         1, 1, 0, 1, 4'b0010, 0);
        // Frame C: good frame to channel 3, directly after the bad trailer
        add(HDR,           1, 1, 0, 0, 4'b0010, 0);
        add(32'h8000_0003, 1, 1, 0, 0, 4'b0010, 0);
        add(32'h1234_5678, 1, 1, 0, 0, 4'b0010, 0);
        add(32'hABC,       1, 1, 0, 0, 4'b0010, 0);
        add(32'd3,         1, 1, 0, 0, 4'b0010, 0);
        add(HDR,           1, 1, 1, 0, 4'b1010, 32'h1234_5678);
        // Frame D: back-to-back, channel 7 out of range
        add(HDR,           1, 1, 0, 0, 4'b1010, 32'h1234_5678);
        add(32'h0000_0007, 1, 1, 0, 0, 4'b1010, 32'h1234_5678);
        add(32'd1,         1, 1, 0, 0, 4'b1010, 32'h1234_5678);
        add(32'd2,         1, 1, 0, 0, 4'b1010, 32'h1234_5678);
        add(32'd3,         1, 1, 0, 0, 4'b1010, 32'h1234_5678);
        add(HDR,           1, 1, 0, 1, 4'b1010, 32'h1234_5678);
        // Garbage in IDLE is dropped
        add(32'h1234_5678, 1, 1, 0, 0, 4'b1010, 32'h1234_5678);

        foreach (vt[i]) begin
            step(vt[i].data, vt[i].valid, vt[i].work);
            chk($sformatf("v%0d_set_flag", i), set_flag, vt[i].exp_set);
            chk($sformatf("v%0d_frame_err", i), frame_err, vt[i].exp_err);
            chk($sformatf("v%0d_dds_en", i), dds_en, vt[i].exp_en);
            chk($sformatf("v%0d_f3", i), f_word[127:96], vt[i].exp_f3);
            if (i == 5) chk("v5_set_ch", set_ch, 1);
        end
        chk("tbl_set_ch", set_ch, 3);
        chk_bank(0, 0, 0, 0);
        chk_bank(1, 32'd1000, 12'h800, 2'd2);
        chk_bank(2, 0, 0, 0);
        chk_bank(3, 32'h1234_5678, 12'hABC, 2'd3);

        // Gaps of 3 idle cycles between words
        s0 = n_set; e0 = n_err;
        frame(32'h8000_0002, 32'hA5A5, 32'hF123, 32'h5, 3, 1'b1);
        chk("gap_commit", n_set - s0, 1);
        chk("gap_no_err", n_err - e0, 0);
        chk("gap_set_ch", set_ch, 2);
        chk("gap_dds_en", dds_en, 4'b1110);
        chk_bank(2, 32'hA5A5, 12'h123, 2'd1);

        // Words arriving when the counter sits at TIMEOUT_CYC-1 are accepted
        s0 = n_set; e0 = n_err;
        step(HDR, 1, 1);
        step(32'h8000_0000, 1, 1);
        step(32'd7, 1, 1);
        step(32'd8, 1, 1);
        idle(TMO - 1, 1);
        step(32'd1, 1, 1);
        idle(TMO - 1, 1);
        step(HDR, 1, 1);
        chk("bound_commit", n_set - s0, 1);
        chk("bound_no_err", n_err - e0, 0);
        chk("bound_dds_en", dds_en, 4'b1111);
        chk_bank(0, 32'd7, 12'd8, 2'd1);

        // Stall after PHASE: exactly one timeout error, on idle cycle TMO
        s0 = n_set; e0 = n_err; err_at = -1;
        step(HDR, 1, 1);
        step(32'h0000_0001, 1, 1);
        step(32'd9, 1, 1);
        step(32'd9, 1, 1);
        for (int i = 1; i <= TMO + 8; i++) begin
            step(32'h0, 0, 1);
            if (frame_err && err_at < 0) err_at = i;
        end
        chk("tmo_err_count", n_err - e0, 1);
        chk("tmo_err_cycle", err_at, TMO);
        chk("tmo_no_commit", n_set - s0, 0);
        chk_bank(1, 32'd1000, 12'h800, 2'd2);

        // dds_work_flag drop mid-frame, full frame while low, then restore
        step(HDR, 1, 1);
        step(32'h0000_0000, 1, 1);
        step(32'h99, 1, 1);
        step(32'h0, 0, 0);
        chk("work_drop_en", dds_en, 4'b0000);
        s0 = n_set; e0 = n_err;
        frame(32'h0000_0000, 32'h55, 32'h1, 32'h0, 0, 1'b0);
        chk("work_low_no_set", n_set - s0, 0);
        chk("work_low_no_err", n_err - e0, 0);
        chk("work_low_en", dds_en, 4'b0000);
        chk_bank(0, 32'd7, 12'd8, 2'd1);
        step(32'h0, 0, 1);
        chk("work_back_en", dds_en, 4'b1111);
        s0 = n_set; e0 = n_err;
        frame(32'h0000_0000, 32'h99, 32'h1, 32'h0, 0, 1'b1);
        chk("work_resume_commit", n_set - s0, 1);
        chk("work_resume_no_err", n_err - e0, 0);
        chk("work_resume_en", dds_en, 4'b1110);
        chk_bank(0, 32'h99, 12'h1, 2'd0);

        // Asynchronous reset in the middle of a frame
        step(HDR, 1, 1);
        step(32'h8000_0002, 1, 1);
        @(negedge clk);
        conf_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_dds_en", dds_en, 0);
        chk("arst_f_word", f_word, 0);
        chk("arst_p_word", p_word, 0);
        chk("arst_wave", wave_type, 0);
        chk("arst_set_ch", set_ch, 0);
        chk("arst_pulses", {set_flag, frame_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        s0 = n_set; e0 = n_err;
        frame(32'h8000_0002, 32'h55, 32'h66, 32'h2, 0, 1'b1);
        chk("post_rst_commit", n_set - s0, 1);
        chk("post_rst_no_err", n_err - e0, 0);
        chk("post_rst_en", dds_en, 4'b0100);
        chk("post_rst_set_ch", set_ch, 2);
        chk_bank(2, 32'h55, 12'h066, 2'd2);
        chk_bank(1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_conf_decoder.md
# dds_conf_decoder

Multi-channel successor to the single-channel DDS configuration decoder. Parses framed 32-bit configuration words arriving from the AXI-side register path and loads frequency word, phase word and waveform type into one of `CH_NUM` per-channel register banks. A bank updates only when a complete, well-formed frame ends with a valid trailer. Sits between the PS configuration interface and the DDS channel cores, all in the `axi_clk` domain.

## Interface
Parameters:
- `CH_NUM`, 4: number of DDS channels (1..16).
- `PW_WIDTH`, 12: phase word width (1..32).
- `WT_WIDTH`, 2: waveform type width (1..8).
- `TIMEOUT_CYC`, 1024: max idle cycles between words inside a frame (≥2).

Ports (clock and reset first):
- `axi_clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `conf_data` in 32: configuration word.
- `conf_valid` in 1: `conf_data` is sampled on cycles where this is high.
- `dds_work_flag` in 1: global enable; low aborts parsing and gates outputs.
- `set_flag` out 1: one-cycle pulse on bank commit.
- `set_ch` out `$clog2(CH_NUM)` (min 1): channel committed by the last `set_flag`.
- `frame_err` out 1: one-cycle pulse on a rejected frame.
- `dds_en` out `CH_NUM`: per-channel enable.
- `f_word` out `CH_NUM*32`: channel k at bits [32k+31:32k].
- `p_word` out `CH_NUM*PW_WIDTH`: packed the same way.
- `wave_type` out `CH_NUM*WT_WIDTH`: packed the same way.

## Operation
- Frame: HEADER 0xFFFF_FFFF, CTRL, FREQ, PHASE, WAVE, TRAILER 0xFFFF_FFFF. Each word is consumed on one `conf_valid` cycle.
- CTRL word: bit 31 is the enable value; bits [7:0] are the channel index; bits [30:8] are ignored.
- FREQ: all 32 bits are used. PHASE: bits [PW_WIDTH-1:0]. WAVE: bits [WT_WIDTH-1:0]. Upper bits are ignored.
- FSM states: IDLE, CTRL, FREQ, PHASE, WAVE, TRAIL.
  - IDLE → CTRL on a valid word equal to 0xFFFF_FFFF. Other valid words in IDLE are dropped silently.
  - CTRL → FREQ → PHASE → WAVE → TRAIL, one valid word per step. Words are captured into shadow registers, including channel index and enable.
  - TRAIL, valid word 0xFFFF_FFFF: commit the shadow registers to bank[ch], load `dds_en[ch]` from the shadow enable, pulse `set_flag`, set `set_ch`, go to IDLE.
  - TRAIL, any other valid word: pulse `frame_err`, no commit, go to IDLE. The offending word is not re-parsed as a header.
- Channel index ≥ CH_NUM: detected in CTRL. `frame_err` pulses at the TRAIL word in place of a commit; the remaining words are still consumed.
- Payload words equal to 0xFFFF_FFFF in FREQ, PHASE or WAVE are legal data. They are not headers.
- Timeout: in any non-IDLE state, a counter runs on cycles without `conf_valid`. It resets on every valid word. When it reaches TIMEOUT_CYC: pulse `frame_err`, discard the shadow registers, go to IDLE.
- `dds_work_flag` low:
  - FSM is forced to IDLE, with no `frame_err`.
  - Incoming words are ignored.
  - `dds_en` reads all-zero.
  - Bank registers and the internal enable bits are retained. `dds_en` reappears one cycle after `dds_work_flag` returns high.
- Uncommitted channels keep their values.

## Timing
- Reset values: FSM in IDLE; `set_flag`, `frame_err`, `set_ch` at 0; all bank fields at 0; internal enables and `dds_en` at 0; timeout counter at 0.
- Commit latency: with the TRAILER sampled at edge N, the bank outputs, `dds_en[ch]`, `set_ch` and `set_flag` all change at edge N (registered). `set_flag` is high for exactly cycle N..N+1.
- Throughput: back-to-back frames are accepted with no gap. A HEADER may follow a TRAILER in the next cycle.
- `dds_en` = internal enable AND registered `dds_work_flag`, giving one cycle of latency on both edges.
- `frame_err` and `set_flag` are never high together.
- Reset asserted mid-frame: everything clears immediately (asynchronous). Parsing resumes from IDLE after release.
- Timeout boundary: a valid word arriving on the cycle the counter equals TIMEOUT_CYC−1 is accepted. The counter saturates and does not wrap.

## Test plan
- Reset release, `dds_work_flag`=1, valid every cycle with FFFF_FFFF, 8000_0001, 1000, 2048, 2, FFFF_FFFF:
  - Expect channel 1 to show f=1000, p=2048 (12-bit: 0x800), wave=2.
  - Expect `dds_en`=4'b0010 and a one-cycle `set_flag` with `set_ch`=1.
  - Channels 0, 2 and 3 stay 0.
- Frame to channel 3 with FREQ=FFFF_FFFF and a bad TRAILER 0: expect `frame_err` pulse, no commit, and channel 3 still 0. A following good frame commits normally.
- CTRL=0000_0007 with CH_NUM=4 and a good trailer: expect `frame_err` and no bank change.
- Valid words with gaps of 3 cycles: expect a commit. Stop after PHASE for TIMEOUT_CYC cycles: expect exactly one `frame_err` and return to IDLE.
- Drop `dds_work_flag` after FREQ, then send a full frame while it is low: expect no `set_flag` or `frame_err`, and `dds_en`=0 one cycle after the drop. Raise the flag again: previous enables reappear one cycle later.
- Pull `rst` low in the middle of a frame: all outputs are 0 immediately. After release, a fresh frame commits correctly.
